// File: rtl/alu_4_bit.sv
// Registered 4-bit ALU: eight opcodes, result plus carry/zero/neg/ovf flags,
// one-cycle latency, one request accepted per clock.
module alu_4_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] SEL,
  input  logic       in_valid,
  output logic [3:0] RESULT,
  output logic       carry,
  output logic       zero,
  output logic       neg,
  output logic       ovf,
  output logic       out_valid
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  // Handshake: a request is accepted on any rising edge where in_valid=1 and
  // rst=0; there is no ready, so the producer never stalls. out_valid is high
  // for exactly the cycle after each accepted request.

  op_e        op;
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [3:0] r_c;
  logic       carry_c;
  logic       ovf_c;

  logic [3:0] result_d, result_q;
  logic       carry_d, carry_q;
  logic       zero_d, zero_q;
  logic       neg_d, neg_q;
  logic       ovf_d, ovf_q;
  logic       out_valid_d, out_valid_q;

  assign op    = op_e'(SEL);
  assign sum5  = {1'b0, A} + {1'b0, B};
  assign diff5 = {1'b0, A} - {1'b0, B};

  // Unary ops never reference B so an undriven B cannot leak into any output.
  always_comb begin
    r_c     = 4'b0000;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (op)
      OP_ADD: begin
        r_c     = sum5[3:0];
        carry_c = sum5[4];
        ovf_c   = (A[3] == B[3]) && (sum5[3] != A[3]);
      end
      OP_SUB: begin
        r_c     = diff5[3:0];
        carry_c = ~diff5[4];
        ovf_c   = (A[3] != B[3]) && (diff5[3] != A[3]);
      end
      OP_AND: r_c = A & B;
      OP_OR:  r_c = A | B;
      OP_NOT: r_c = ~A;
      OP_XOR: r_c = A ^ B;
      OP_SHL: begin
        r_c     = {A[2:0], 1'b0};
        carry_c = A[3];
      end
      OP_SHR: begin
        r_c     = {1'b0, A[3:1]};
        carry_c = A[0];
      end
      default: begin
        r_c     = 4'b0000;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = r_c;
      carry_d  = carry_c;
      zero_d   = (r_c == 4'b0000);
      neg_d    = r_c[3];
      ovf_d    = ovf_c;
    end
  end

  // zero clears with the rest: no valid result exists straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= 4'b0000;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign RESULT    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_4_bit.sv
// Directed and exhaustive checks for alu_4_bit; outputs are compared on the
// falling edge after the rising edge that captured each request.
module tb_alu_4_bit;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] sel;
  logic       in_valid;
  logic [3:0] result;
  logic       carry;
  logic       zero;
  logic       neg;
  logic       ovf;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  alu_4_bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (a),
    .B         (b),
    .SEL       (sel),
    .in_valid  (in_valid),
    .RESULT    (result),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packing: {out_valid, ovf, neg, zero, carry, result[3:0]}
  function automatic logic [8:0] observed();
    return {out_valid, ovf, neg, zero, carry, result};
  endfunction

  function automatic logic [8:0] pack(input logic v, input logic o, input logic n,
                                      input logic z, input logic c, input logic [3:0] r);
    return {v, o, n, z, c, r};
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = observed();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got v/o/n/z/c/r=%b expected=%b", tag, got, exp);
    end
  endtask

  // Driver: present a request, then advance to the next falling edge
  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic [2:0] ts,
                       input logic tv);
    a        = ta;
    b        = tb_;
    sel      = ts;
    in_valid = tv;
    @(negedge clk);
  endtask

  // Reference model built on integer arithmetic and signed range checks
  function automatic logic [8:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic [2:0] ms);
    int ua, ub, sa, sb, t, res;
    logic c, o;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    c = 1'b0;
    o = 1'b0;
    res = 0;
    case (ms)
      3'd0: begin
        t = ua + ub;
        res = t % 16;
        c = (t >= 16);
        o = ((sa + sb) > 7) || ((sa + sb) < -8);
      end
      3'd1: begin
        t = ua - ub;
        res = (t + 16) % 16;
        c = (ua >= ub);
        o = ((sa - sb) > 7) || ((sa - sb) < -8);
      end
      3'd2: res = int'(ma & mb);
      3'd3: res = int'(ma | mb);
      3'd4: res = 15 - ua;
      3'd5: res = int'(ma ^ mb);
      3'd6: begin
        res = (ua * 2) % 16;
        c = (ua >= 8);
      end
      default: begin
        res = ua / 2;
        c = (ua % 2) == 1;
      end
    endcase
    return pack(1'b1, o, res >= 8, res == 0, c, res[3:0]);
  endfunction

  initial begin
    rst = 1'b1;
    a = 4'h0;
    b = 4'h0;
    sel = 3'd0;
    in_valid = 1'b0;
    @(negedge clk);

    // Reset held two cycles with live requests: all must be discarded
    drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1);
    check("reset_cycle1", pack(0, 0, 0, 0, 0, 4'h0));
    drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1);
    check("reset_cycle2", pack(0, 0, 0, 0, 0, 4'h0));
    rst = 1'b0;

    // Directed operations
    drive(4'b0101, 4'b0011, 3'd0, 1'b1);
    check("add_0101_0011", pack(1, 1, 1, 0, 0, 4'b1000));
    drive(4'b1001, 4'b0001, 3'd1, 1'b1);
    check("sub_1001_0001", pack(1, 0, 1, 0, 1, 4'b1000));
    drive(4'b1100, 4'b1010, 3'd2, 1'b1);
    check("and_1100_1010", pack(1, 0, 1, 0, 0, 4'b1000));
    drive(4'b1100, 4'b1010, 3'd3, 1'b1);
    check("or_1100_1010", pack(1, 0, 1, 0, 0, 4'b1110));
    drive(4'b0101, 4'bxxxx, 3'd4, 1'b1);
    check("not_0101_bx", pack(1, 0, 1, 0, 0, 4'b1010));

    // Wrap and borrow
    drive(4'b1111, 4'b0001, 3'd0, 1'b1);
    check("add_wrap", pack(1, 0, 0, 1, 1, 4'b0000));
    drive(4'b0000, 4'b0001, 3'd1, 1'b1);
    check("sub_borrow", pack(1, 0, 1, 0, 0, 4'b1111));
    drive(4'b1000, 4'b0001, 3'd1, 1'b1);
    check("sub_ovf", pack(1, 1, 0, 0, 1, 4'b0111));

    // Shifts and XOR (B left undriven for shifts)
    drive(4'b1001, 4'bxxxx, 3'd6, 1'b1);
    check("shl_1001", pack(1, 0, 0, 0, 1, 4'b0010));
    drive(4'b1001, 4'bxxxx, 3'd7, 1'b1);
    check("shr_1001", pack(1, 0, 0, 0, 1, 4'b0100));
    drive(4'b1100, 4'b1010, 3'd5, 1'b1);
    check("xor_1100_1010", pack(1, 0, 0, 0, 0, 4'b0110));

    // Five back-to-back requests
    drive(4'b0111, 4'b0001, 3'd0, 1'b1);
    check("b2b_0_add", pack(1, 1, 1, 0, 0, 4'b1000));
    drive(4'b0011, 4'b0101, 3'd1, 1'b1);
    check("b2b_1_sub", pack(1, 0, 1, 0, 0, 4'b1110));
    drive(4'b0000, 4'b0000, 3'd3, 1'b1);
    check("b2b_2_or", pack(1, 0, 0, 1, 0, 4'b0000));
    drive(4'b1000, 4'b0110, 3'd6, 1'b1);
    check("b2b_3_shl", pack(1, 0, 0, 1, 1, 4'b0000));
    drive(4'b0001, 4'b1111, 3'd7, 1'b1);
    check("b2b_4_shr", pack(1, 0, 0, 1, 1, 4'b0000));

    // Idle with changing inputs: outputs hold, out_valid drops
    drive(4'b0101, 4'b0011, 3'd0, 1'b0);
    check("hold_1", pack(0, 0, 0, 1, 1, 4'b0000));
    drive(4'b1110, 4'b0111, 3'd4, 1'b0);
    check("hold_2", pack(0, 0, 0, 1, 1, 4'b0000));

    // Request presented together with reset is discarded
    rst = 1'b1;
    drive(4'b0101, 4'b0011, 3'd0, 1'b1);
    check("rst_discard", pack(0, 0, 0, 0, 0, 4'h0));
    rst = 1'b0;
    drive(4'b0010, 4'b0011, 3'd0, 1'b1);
    check("post_rst_add", pack(1, 0, 0, 0, 0, 4'b0101));

    // Exhaustive sweep, back-to-back
    for (int s = 0; s < 8; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          drive(4'(ia), 4'(ib), 3'(s), 1'b1);
          check($sformatf("sweep_s%0d_a%0d_b%0d", s, ia, ib), model(4'(ia), 4'(ib), 3'(s)));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
